seg_display_arbiter: RTL
========================

Name: seg_display_arbiter

Overview:
- Owns the 4-digit seven-segment display for the CPU lab board.
- Shares the display between two requesters through a valid/ready write handshake, e.g. src0 = CPU debug bus (PC/register value) and src1 = user/switch path.
- Holds each accepted value on screen for a minimum number of full refresh frames.
- Generates the multiplexed digit scan from the system clock with an internal prescaler.

Parameters:
- CLK_DIV, 100000: system-clock cycles per digit-scan tick; must be >= 2.
- HOLD_FRAMES, 4: full 4-digit frames a value stays locked before a new write is accepted; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- src0_valid  in  1  requester 0 has a value
- src0_data  in  16  requester 0 value; digit 0 = bits [3:0]
- src0_ready  out  1  requester 0 write accepted this cycle when valid is also high
- src1_valid  in  1  requester 1 has a value
- src1_data  in  16  requester 1 value
- src1_ready  out  1  requester 1 write accepted
- last_src  out  1  source of the currently displayed value
- busy  out  1  high while in HOLD
- ano  out  4  digit enables, active-low, one-hot
- leds  out  7  segments, active-low, order {g,f,e,d,c,b,a}
- dot  out  1  decimal point, active-low; driven constant 1 (off)

Behaviour:
- Decided interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - prescaler 0, digit index 0, scan_on 0, value latch 16'h0000
  - last_src 1, state IDLE, hold counter 0
  - ano 4'b1111, leds 7'b1111111, dot 1
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick is high in the cycle where the count equals CLK_DIV-1.
- Scan:
  - First tick after reset sets scan_on; the digit index stays 0.
  - Each later tick increments the index, wrapping 3 to 0.
  - frame_end = tick while the index is 3 and scan_on is set.
  - While scan_on is 0: ano = 1111 and leds = blank.
  - Otherwise ano = ~(1 << index), and leds = hex decode of latch nibble[index].
  - ano and leds are combinational from the index and latch.
- Arbitration (combinational grant):
  - Only src0 valid: grant 0. Only src1 valid: grant 1.
  - Both valid: grant = ~last_src (round-robin). Neither valid: no grant.
  - srcN_ready = (state == IDLE) && grant == N. Ready may depend on valid.
- State machine:
  - IDLE to HOLD on a transfer (valid && ready). On that edge: latch <= data, last_src <= N, hold counter <= 0.
  - In HOLD: the hold counter increments on each frame_end.
  - HOLD to IDLE on the frame_end where the counter equals HOLD_FRAMES-1.
  - Both readys are low in HOLD. busy = (state == HOLD).
- Timing:
  - A new value appears on leds the cycle after transfer.
  - The first hold frame is partial: it counts from transfer to the next frame_end.
- Requester behaviour:
  - A requester may drop valid without a transfer; there is no state effect.
  - A value presented during HOLD is not consumed.
- Reset mid-HOLD or mid-scan: all state returns to reset values the next cycle, with no partial transfer.

Optional Feature:
- SEG_LEADING_ZERO_BLANK_EN defined:
  - Any digit whose nibble and all higher nibbles are 0 has its ano bit forced high (off).
  - Digit 0 is never blanked, so 16'h0000 shows "0" and 16'h00A3 shows "A3".
- Undefined: all four digits are always shown, so 16'h00A3 shows "00A3".

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK = 7'h7F and AN_OFF = 4'hF
  - the 16-entry hex segment table: 0=1000000, 1=1111001, ..., A=0001000, b=0000011, C=0100111, d=0100001, E=0000110, F=0001110
  - the two-state enum {IDLE, HOLD}
- One sub-module, seg_hex_decode: 4-bit nibble in, 7-bit active-low segments out, purely combinational.

Test Plan (CLK_DIV=4, HOLD_FRAMES=2; one frame = 16 cycles):
- Reset release: ano = 1111 for the first 4 cycles. Then ano = 1110 with leds = 1000000 ("0"). The sequence 1101, 1011, 0111 follows at 4-cycle spacing.
- src0 writes 16'h1234 with src1 idle: src0_ready = 1 the same cycle. Next cycle busy = 1, last_src = 0. Digits 0..3 show 4, 3, 2, 1.
- Write src1 16'hBEEF during HOLD: src1_ready stays 0 until busy falls at the second frame_end. Then the transfer occurs and leds on digit 0 = 0001110.
- Both valid in IDLE with last_src = 1: src0 is granted first. After its hold, src1 is granted. The sequence alternates over 4 transfers.
- Assert rst mid-HOLD: next cycle ano = 1111, busy = 0, last_src = 1, and the latch reads 0000 once scanning resumes.
- With SEG_LEADING_ZERO_BLANK_EN, write 16'h0007: only ano = 1110 ever goes low, showing 1111000. Without the macro, all four digits show 0, 0, 0, 7.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, segment table and FSM state type for the seven-segment display arbiter.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b0100111,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic {IDLE, HOLD} state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for the 4-digit seven-segment display with frame-based hold and scan.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to switch off leading zero digits (digit 0 always shown).
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        src0_valid,
  input  logic [15:0] src0_data,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [15:0] src1_data,
  output logic        src1_ready,
  output logic        last_src,
  output logic        busy,
  output logic [3:0]  ano,
  output logic [6:0]  leds,
  output logic        dot
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic          scan_on_q;
  logic          tick;
  logic          frame_end;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   latch_q, latch_d;
  logic          last_q, last_d;
  logic          grant;

  assign tick      = (presc_q == PW'(CLK_DIV - 1));
  assign frame_end = tick && scan_on_q && (idx_q == 2'd3);

  // The first tick only enables scanning; later ticks advance the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= 2'd0;
      scan_on_q <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (scan_on_q) idx_q <= idx_q + 2'd1;
        scan_on_q <= 1'b1;
      end
    end
  end

  // Round-robin on contention: favour the source that did not win last time.
  assign grant      = src1_valid && (!src0_valid || !last_q);
  assign src0_ready = (state_q == IDLE) && src0_valid && !grant;
  assign src1_ready = (state_q == IDLE) && grant;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    latch_d = latch_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (src0_ready || src1_ready) begin
          state_d = HOLD;
          hold_d  = '0;
          latch_d = grant ? src1_data : src0_data;
          last_d  = grant;
        end
      end
      HOLD: begin
        if (frame_end) begin
          if (hold_q == HW'(HOLD_FRAMES - 1)) state_d = IDLE;
          else                                hold_d  = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      latch_q <= 16'h0000;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      latch_q <= latch_d;
      last_q  <= last_d;
    end
  end

  assign busy     = (state_q == HOLD);
  assign last_src = last_q;
  assign dot      = 1'b1;

  logic [3:0] nibble;
  logic [6:0] seg;

  assign nibble = latch_q[{idx_q, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (seg)
  );

  always_comb begin
    ano  = AN_OFF;
    leds = SEG_BLANK;
    if (scan_on_q) begin
      ano  = ~(4'b0001 << idx_q);
      leds = seg;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      case (idx_q)
        2'd1:    if (latch_q[15:4] == 12'h000) ano = AN_OFF;
        2'd2:    if (latch_q[15:8] == 8'h00) ano = AN_OFF;
        2'd3:    if (latch_q[15:12] == 4'h0) ano = AN_OFF;
        default: ;
      endcase
`endif
    end
  end

endmodule
